// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared constants for the adder family. Blocks import this package and
//   take their default operand and segment widths from it.
//   No ports: package only.
package adder_pkg;

  // Default operand / sum width in bits.
  localparam int ADDER_WIDTH = 32;

  // Default carry-bypass segment width in bits.
  localparam int ADDER_SEG_W = 8;

  // Number of bypass segments (and therefore pipeline stages) for a given
  // width. The width is expected to be a whole multiple of the segment width.
  function automatic int seg_count(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/bypass_segment.sv
// bypass_segment
//   Purely combinational SEG_W-bit carry-bypass adder slice. It has no state.
//   Ports:
//     a, b   : segment operand bits (b is already inverted for subtract)
//     cin    : carry into the segment
//     s      : segment sum bits
//     cout   : carry out of the segment (bypassed when every bit propagates)
//     p      : group propagate, AND of (a_i XOR b_i)
//     c_msb  : carry into the segment's most significant bit
module bypass_segment
  import adder_pkg::*;
#(
  parameter int SEG_W = ADDER_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             p,
  output logic             c_msb
);

  logic [SEG_W:0] carry_s;

  // Ripple sum inside the segment; the group carry-out skips the ripple
  // chain whenever every bit propagates.
  always_comb begin
    carry_s    = '0;
    carry_s[0] = cin;
    s          = '0;
    for (int i = 0; i < SEG_W; i++) begin
      s[i]           = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry_s[i]);
    end
    p     = &(a ^ b);
    // With full propagate the ripple result equals cin anyway; selecting cin
    // directly is what shortens the critical path in a wider chain.
    if (p) begin
      cout = cin;
    end else begin
      cout = carry_s[SEG_W];
    end
    c_msb = carry_s[SEG_W-1];
  end

endmodule

// File: rtl/pipelined_bypass_adder.sv
// pipelined_bypass_adder
//   Add/subtract unit split into NSEG = WIDTH/SEG_W carry-bypass segments,
//   one segment resolved per pipeline stage, with a valid/ready handshake on
//   both sides. All stages advance together under a single global enable.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     in_valid, in_ready : input beat handshake
//     a, b, Cin, sub     : operands, carry/borrow-in, 0 = add / 1 = subtract
//     S, Cout, Overflow  : registered result, carry out, signed overflow
//     out_valid, out_ready : output beat handshake
module pipelined_bypass_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int SEG_W = ADDER_SEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSEG = seg_count(WIDTH, SEG_W);

  // Per-stage registers: the beat's valid bit, the operands it still needs
  // for the upper segments, the sum bits resolved so far, and the carry
  // out of the segment this stage resolved.
  logic [NSEG-1:0]  valid_r;
  logic [WIDTH-1:0] a_r   [NSEG];
  logic [WIDTH-1:0] b_r   [NSEG];
  logic [WIDTH-1:0] s_r   [NSEG];
  logic [NSEG-1:0]  carry_r;
  logic             ov_r;

  // What each stage sees on its input side (the previous stage, or the
  // input port for stage 0).
  logic [WIDTH-1:0] a_src_s   [NSEG];
  logic [WIDTH-1:0] b_src_s   [NSEG];
  logic [WIDTH-1:0] s_src_s   [NSEG];
  logic [NSEG-1:0]  cin_src_s;
  logic [NSEG-1:0]  v_src_s;

  // Segment results for the segment each stage resolves.
  logic [SEG_W-1:0] seg_sum_s  [NSEG];
  logic [NSEG-1:0]  seg_cout_s;
  logic             seg_cmsb_s [NSEG];
  // Group propagate is consumed inside the segment for its bypass mux; the
  // pipeline itself has no further use for it.
  logic [NSEG-1:0]  seg_p_unused_s;

  logic en_s;

  // The whole pipe moves unless a finished beat is stuck at the output.
  assign en_s      = ~valid_r[NSEG-1] | out_ready;
  assign in_ready  = en_s;

  assign S         = s_r[NSEG-1];
  assign Cout      = carry_r[NSEG-1];
  assign Overflow  = ov_r;
  assign out_valid = valid_r[NSEG-1];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is a + ~b + 1 - Cin, i.e. invert b and the carry-in.
      assign a_src_s[k]   = a;
      assign b_src_s[k]   = b ^ {WIDTH{sub}};
      assign s_src_s[k]   = '0;
      assign cin_src_s[k] = Cin ^ sub;
      assign v_src_s[k]   = in_valid;
    end else begin : g_body
      assign a_src_s[k]   = a_r[k-1];
      assign b_src_s[k]   = b_r[k-1];
      assign s_src_s[k]   = s_r[k-1];
      assign cin_src_s[k] = carry_r[k-1];
      assign v_src_s[k]   = valid_r[k-1];
    end

    bypass_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a     (a_src_s[k][k*SEG_W +: SEG_W]),
      .b     (b_src_s[k][k*SEG_W +: SEG_W]),
      .cin   (cin_src_s[k]),
      .s     (seg_sum_s[k]),
      .cout  (seg_cout_s[k]),
      .p     (seg_p_unused_s[k]),
      .c_msb (seg_cmsb_s[k])
    );
  end

  // Pipeline registers: reset clears everything; otherwise all stages load
  // together when enabled, and a bubble only moves its valid bit so the
  // data registers (and hence S) keep their last real value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      carry_r <= '0;
      ov_r    <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else if (en_s) begin
      valid_r <= v_src_s;
      for (int k = 0; k < NSEG; k++) begin
        if (v_src_s[k]) begin
          a_r[k]                   <= a_src_s[k];
          b_r[k]                   <= b_src_s[k];
          s_r[k]                   <= s_src_s[k];
          s_r[k][k*SEG_W +: SEG_W] <= seg_sum_s[k];
          carry_r[k]               <= seg_cout_s[k];
        end
      end
      // Signed overflow: carry into the top bit differs from carry out.
      if (v_src_s[NSEG-1]) begin
        ov_r <= seg_cmsb_s[NSEG-1] ^ seg_cout_s[NSEG-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
module tb_pipelined_bypass_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic clk;
  logic rst;

  // 32-bit / 8-bit segment instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, S;
  logic        cin, sub, cout, ovf;

  // 16-bit / 4-bit segment instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, S16;
  logic        cin16, sub16, cout16, ovf16;

  int n_vec = 0;
  int n_err = 0;

  bit   mon32_en = 1'b0;
  bit   mon16_en = 1'b0;
  res_t q32[$];
  res_t q16[$];
  int   acc16 = 0;
  int   out16 = 0;

  vec_t tbl[10];

  pipelined_bypass_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .Cin(cin), .sub(sub), .S(S), .Cout(cout), .Overflow(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipelined_bypass_adder #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .Cin(cin16), .sub(sub16), .S(S16), .Cout(cout16),
    .Overflow(ovf16), .out_valid(out_valid16), .out_ready(out_ready16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a + b_eff + c0 on a w-bit datapath, carry into the top bit
  // taken from the separate (w-1)-bit sum.
  function automatic res_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                 input logic ci, input logic sb);
    logic [63:0] mask, lmask, beff, full, low, c0;
    res_t r;
    mask  = (64'd1 << w) - 64'd1;
    lmask = (64'd1 << (w - 1)) - 64'd1;
    beff  = (sb ? ~{32'd0, bb} : {32'd0, bb}) & mask;
    c0    = {63'd0, ci ^ sb};
    full  = {32'd0, aa} + beff + c0;
    low   = ({32'd0, aa} & lmask) + (beff & lmask) + c0;
    r.s   = full[31:0] & mask[31:0];
    r.c   = full[w];
    r.v   = low[w-1] ^ full[w];
    return r;
  endfunction

  task automatic mon32();
    bit   held = 1'b0;
    res_t held_val = '0;
    res_t got, exp;
    forever begin
      @(negedge clk);
      if (mon32_en) begin
        got = {S, cout, ovf};
        if (held) chk("stall_hold32", got, held_val);
        chk("in_ready32", in_ready, !out_valid || out_ready);
        if (in_valid && in_ready) q32.push_back(model(32, a, b, cin, sub));
        if (out_valid && out_ready) begin
          if (q32.size() == 0) begin
            chk("extra_beat32", 1, 0);
          end else begin
            exp = q32.pop_front();
            chk("stream32", got, exp);
          end
        end
        held     = out_valid && !out_ready;
        held_val = got;
      end
    end
  endtask

  task automatic mon16();
    bit   held = 1'b0;
    res_t held_val = '0;
    res_t got, exp;
    forever begin
      @(negedge clk);
      if (mon16_en) begin
        got = {16'd0, S16, cout16, ovf16};
        if (held) chk("stall_hold16", got, held_val);
        if (in_valid16 && in_ready16) begin
          q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, sub16));
          acc16++;
        end
        if (out_valid16 && out_ready16) begin
          out16++;
          if (q16.size() == 0) begin
            chk("extra_beat16", 1, 0);
          end else begin
            exp = q16.pop_front();
            chk("random16", got, exp);
          end
        end
        held     = out_valid16 && !out_ready16;
        held_val = got;
      end
    end
  endtask

  initial begin
    tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[1] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[9] = '{32'h00FF_00FF, 32'h0001_FF01, 1'b0, 1'b0, 32'h0101_0000, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;

    fork
      mon32();
      mon16();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Directed table, one beat at a time, latency 4
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
      @(posedge clk); #1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("tbl_not_early", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_S", S, tbl[i].s);
      chk("tbl_cout", cout, tbl[i].c);
      chk("tbl_ovf", ovf, tbl[i].v);
    end

    // Reset with three beats in flight
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 32'h1111_0000 * (j + 1); b = 32'h0000_0101; cin = 1'b0; sub = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_S", S, 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("flush_no_emerge", out_valid, 0);
    end

    // Ten back-to-back beats, results on consecutive cycles
    mon32_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 10);
      a = 32'h0123_4567 * (i + 1); b = 32'hF00D_0001 ^ (32'h1 << i);
      cin = i[0]; sub = i[1];
      @(negedge clk);
      chk("b2b_out_valid", out_valid, (i >= 4 && i <= 13));
    end

    // Mid-stream stall of three cycles
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 12);
      out_ready = !(i >= 6 && i <= 8);
      a = 32'h8765_4321 + 32'h1000_0003 * i; b = 32'h7FFF_FFF0 + i; cin = i[1]; sub = i[0];
      @(negedge clk);
      chk("stall_in_ready", in_ready, !(i >= 6 && i <= 8));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain32_empty", q32.size(), 0);
    mon32_en = 1'b0;

    // 16-bit / 4-bit instance, random handshakes
    mon16_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      in_valid16  = 1'($urandom_range(0, 1));
      out_ready16 = 1'($urandom_range(0, 3) != 0);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      sub16 = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain16_empty", q16.size(), 0);
    chk("count16", out16, acc16);
    mon16_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
